// File: rtl/data_mem_seq_if.sv
// Core-port and dump-stream signal bundle for data_mem_seq.
// master = the processor/sink side, slave = the memory.
interface data_mem_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              End;
  logic [DATA_W-1:0] q;
  logic              busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_done;

  modport master (
    output data, addr, we, End, dump_ready,
    input  q, busy, dump_valid, dump_data, dump_addr, dump_done
  );

  modport slave (
    input  data, addr, we, End, dump_ready,
    output q, busy, dump_valid, dump_data, dump_addr, dump_done
  );
endinterface

// File: rtl/data_mem_seq.sv
// Single-port data memory with a post-reset zero-clear sequencer and a
// valid/ready dump stream of a fixed address window, triggered by End.
module data_mem_seq #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 3075,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 300
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_seq_if.slave bus
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_X    = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DUMP_FIRST = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] DUMP_LAST  = ADDR_W'(DUMP_BASE + DUMP_LEN - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, DLOAD, DUMP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // One shared read port: core address in IDLE, the next dump word otherwise.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addr;
    wr_data = bus.data;
    rd_addr = bus.addr;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr;
        wr_data = '0;
      end
      IDLE:  wr_en   = bus.we && in_range(bus.addr);
      DLOAD: rd_addr = DUMP_FIRST;
      DUMP:  rd_addr = bus.dump_addr + 1'b1;
      default: ;
    endcase
  end

  assign rd_data = in_range(rd_addr) ? mem[rd_addr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CLEAR;
      ptr            <= '0;
      bus.q          <= '0;
      bus.busy       <= 1'b1;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= '0;
      bus.dump_addr  <= '0;
      bus.dump_done  <= 1'b0;
    end else begin
      bus.dump_done <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == CLR_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        IDLE: begin
          if (!bus.we) bus.q <= rd_data;
          // A write in the same cycle commits first; DLOAD then reads it back.
          if (bus.End) begin
            state    <= DLOAD;
            bus.busy <= 1'b1;
          end
        end
        DLOAD: begin
          bus.dump_data  <= rd_data;
          bus.dump_addr  <= DUMP_FIRST;
          bus.dump_valid <= 1'b1;
          state          <= DUMP;
        end
        DUMP: begin
          if (bus.dump_ready) begin
            if (bus.dump_addr == DUMP_LAST) begin
              bus.dump_valid <= 1'b0;
              bus.dump_done  <= 1'b1;
              bus.busy       <= 1'b0;
              state          <= IDLE;
            end else begin
              bus.dump_addr <= bus.dump_addr + 1'b1;
              bus.dump_data <= rd_data;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: doc/data_mem_seq.md
# data_mem_seq

Parametrised single-port data memory for the processor datapath, the successor to the fixed 32-bit × 3075-word data RAM. Width, depth and dump window are parameters. File-based load and dump are replaced by two synthesisable sequencers:
- a hardware zero-clear after reset;
- a valid/ready result-dump stream started by `End`.

The core port keeps the existing one-cycle registered-read behaviour.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits
- `ADDR_W`, 12, address width; requires DEPTH ≤ 2^ADDR_W
- `DEPTH`, 3075, number of words
- `DUMP_BASE`, 0, first word address streamed on dump
- `DUMP_LEN`, 300, words streamed on dump; requires ≥ 1 and DUMP_BASE + DUMP_LEN ≤ DEPTH

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `data` in DATA_W: core write data
- `addr` in ADDR_W: core address
- `we` in 1: 1 = write, 0 = read
- `End` in 1: dump request, level-sampled
- `q` out DATA_W: registered core read data
- `busy` out 1: 1 while clearing or dumping; core access ignored
- `dump_valid` out 1: dump word available
- `dump_ready` in 1: sink accepts dump word
- `dump_data` out DATA_W: dump word
- `dump_addr` out ADDR_W: address of current dump word
- `dump_done` out 1: one-cycle pulse after last dump handshake

## Operation
- States:
  - CLEAR: writes 0 to every word, one per cycle, using an internal pointer 0..DEPTH-1.
  - IDLE: serves the core port.
  - DLOAD: fetches the first dump word.
  - DUMP: streams the dump window.
- Transitions:
  - `rst` → CLEAR, pointer 0.
  - CLEAR → IDLE on the edge that writes word DEPTH-1.
  - IDLE + `End` → DLOAD.
  - DLOAD → DUMP (one cycle).
  - DUMP → IDLE on the handshake of word DUMP_BASE+DUMP_LEN-1.
- IDLE core port:
  - `we`=1: mem[addr] ← data; `q` holds its value.
  - `we`=0: `q` ← mem[addr].
  - addr ≥ DEPTH: write dropped; read returns 0.
- `End` and `we` in the same IDLE cycle: the write commits, then the dump starts. The dump observes the new data.
- `End` outside IDLE is ignored. `End` is not latched.
- DLOAD: `dump_data` ← mem[DUMP_BASE], `dump_addr` ← DUMP_BASE, `dump_valid` ← 1.
- DUMP handshake (`dump_valid` & `dump_ready`):
  - If more words remain, load the next word and address; `dump_valid` stays 1 (no bubble).
  - After the last word, `dump_valid` ← 0 and `dump_done` ← 1 for one cycle.
- Without a handshake, `dump_data` and `dump_addr` hold stable while `dump_valid` = 1.
- `busy` = 1 in CLEAR, DLOAD and DUMP. In those states `we`, `addr` and `data` are ignored and `q` holds.
- If `End` is still high when the dump finishes, a new dump starts on the next IDLE cycle (level semantics).

## Timing
- Reset values: `q`=0, `busy`=1, `dump_valid`=0, `dump_data`=0, `dump_addr`=0, `dump_done`=0, state CLEAR.
- Clear:
  - Takes DEPTH cycles after `rst` deasserts.
  - `busy` falls after edge DEPTH; the first accepted core access is in that cycle.
- Read latency: 1 cycle (address at edge n → `q` valid after edge n).
- Write latency: visible to a read issued on the next cycle.
- Dump, with `End` sampled at edge k and `dump_ready` tied 1:
  - `dump_valid` rises after edge k+1.
  - Handshakes occur at edges k+2..k+DUMP_LEN+1.
  - `dump_done` is high for the single cycle after edge k+DUMP_LEN+1; `busy` is 0 in that same cycle.
- Backpressure stalls the stream indefinitely; there is no timeout.
- `rst` mid-dump or mid-clear:
  - Aborts immediately; `dump_valid` ← 0 and no `dump_done`.
  - Clear restarts from word 0.

## Test plan
- Reset, then hold `rst`=0 for DEPTH cycles: `busy`=1 for exactly 3075 cycles, then 0. Reading addresses 0, 1537 and 3074 returns 0.
- Write 0xDEADBEEF to 5, then read 5 on the next cycle: `q`=0xDEADBEEF one cycle later. Write to addr 4000 is dropped; read of 4000 returns 0.
- Fill words 0..299 with value = addr + 1, then pulse `End` with `dump_ready`=1:
  - 300 consecutive beats, `dump_data` = 1..300 and `dump_addr` = 0..299;
  - `dump_done` pulses one cycle after the last beat.
- Repeat the dump with `dump_ready` toggling randomly: same 300-word sequence with no loss or duplication; data stable while stalled.
- Same-cycle `End` and write of 0x55 to addr 0: first dump beat is 0x55. Core writes during the dump are ignored (verify by a post-dump read).
- Assert `rst` at dump beat 150: `dump_valid` drops the next cycle, no `dump_done`, clear restarts, and the memory reads back all zeros.
